vertex_transform: RTL and testbench
===================================

// Module: vertex_transform
// PURPOSE
//  Sequential 4x4 matrix * vertex multiplier. Sits directly downstream of the
//  model-matrix generator. Latches a 16-entry model matrix and a vertex
//  (x,y,z, implicit w=1.0), then computes M*[x y z 1]^T with one shared signed
//  multiplier (one MAC per cycle). Hands the transformed vertex to the
//  view/projection stage over a valid/ready handshake.
// PARAMETERS
//  WI    8   integer bits of every fixed-point operand/result (signed, incl. sign)
//  WF    8   fractional bits of every fixed-point operand/result
// PORTS
//  Clk          in   1           system clock, rising edge
//  Reset        in   1           asynchronous, active-high reset
//  in_valid     in   1           matrix+vertex presented
//  in_ready     out  1           block can accept (high only in IDLE)
//  model_matrix in   16*(WI+WF)  row-major; entry k = row k/4, col k%4
//  vx, vy, vz   in   WI+WF each  vertex coordinates
//  out_valid    out  1           result available
//  out_ready    in   1           downstream accepts result
//  ox,oy,oz,ow  out  WI+WF each  transformed vertex (rows 0..3)
//  overflow     out  1           at least one output saturated for this vertex
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, counter=0, accumulator=0, out_valid=0,
//   overflow=0, ox/oy/oz/ow=0. An in-flight vertex is discarded, never emitted.
//  Number format: signed two's complement Q(WI).(WF); w input is constant
//   1.0 = (1<<WF).
//  States:
//   IDLE: in_ready=1. On in_valid&in_ready, latch matrix, vx, vy, vz; clear the
//    accumulator and the sticky overflow; go to MAC with cnt=0.
//   MAC:  in_ready=0. Each cycle: row=cnt[3:2], col=cnt[1:0],
//    acc += M[row][col]*V[col].
//    Product: full 2*(WI+WF) bits, Q(2WI).(2WF).
//    Accumulator: 2*(WI+WF)+2 bits, so no internal overflow over 4 terms.
//    When col==3: the row result is the accumulator including this term.
//     Round half-up: add 1<<(WF-1), then arithmetic shift right by WF.
//     Saturate to WI+WF bits: 0x7FFF / 0x8000 for defaults.
//     Write the row result to the output register for that row (0->ox ...
//     3->ow). Set overflow if saturation occurred (sticky for the vertex).
//     Clear the accumulator for the next row.
//    cnt wraps from 15 -> DONE.
//   DONE: out_valid=1. ox..ow and overflow are stable and held while
//    out_ready=0. On out_ready: out_valid=0 next cycle, go to IDLE.
//  Latency: accept on edge N. MAC occupies edges N+1..N+16. out_valid is high
//   after edge N+16. Throughput is one vertex per 18 cycles with out_ready
//   tied high.
//  Ordering rules:
//   - No new vertex is accepted while in MAC or DONE; in_valid there is ignored.
//   - Input ports may change freely after acceptance (they are latched).
//   - No combinational path from in_valid/out_ready to in_ready/out_valid.
//  Output registers ox..ow update only during MAC row writes. They are not
//   cleared between vertices.
// TESTING
//  1. Identity matrix (diag 0x0100), v=(0x0100,0x0200,0x0300)
//     -> out=(0x0100,0x0200,0x0300,0x0100), overflow=0.
//     out_valid exactly 16 cycles after the accept edge.
//  2. Model matrix for scale=2.0, angle=0, translate=(1,0,0), v=(1,1,1)
//     -> (0x0300,0x0200,0x0200,0x0100).
//  3. Signed/round: M[0][0]=0xFE80 (-1.5), v.x=0x0080 (0.5), rest 0
//     -> ox=0xFF40 (-0.75). M[0][0]=0x0001, vx=0x0080 -> ox=0x0001 (half-up).
//  4. Saturation: M[0][0]=0x7F00, vx=0x0200 -> ox=0x7FFF, overflow=1.
//     M[0][0]=0x8000, vx=0x0200 -> ox=0x8000, overflow=1.
//     The next clean vertex reports overflow=0.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs constant,
//     in_ready=0. in_valid pulses are ignored (no second result).
//  6. Assert Reset at MAC cnt=7 -> out_valid=0, outputs 0, in_ready=1 after
//     release. The next vertex produces a correct result.

Source files
------------

// File: rtl/vertex_transform.sv
// Sequential 4x4 matrix * vertex multiplier, one shared signed MAC per cycle.
// Latches a model matrix and vertex (w = 1.0), emits M*[x y z 1]^T.
//
// Ports:
//   Clk, Reset        clock (rising edge), async active-high reset
//   in_valid/in_ready accept handshake; in_ready is high only in IDLE
//   model_matrix      16 entries, row-major, entry k at [k*W +: W]
//                     (entry k = row k/4, col k%4)
//   vx, vy, vz        vertex coordinates, signed Q(WI).(WF)
//   out_valid/ready   result handshake
//   ox, oy, oz, ow    transformed vertex (rows 0..3), saturated
//   overflow          sticky: some row of this vertex saturated
module vertex_transform #(
    parameter int WI = 8,
    parameter int WF = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [16*(WI+WF)-1:0]    model_matrix,
    input  logic [WI+WF-1:0]         vx,
    input  logic [WI+WF-1:0]         vy,
    input  logic [WI+WF-1:0]         vz,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WI+WF-1:0]         ox,
    output logic [WI+WF-1:0]         oy,
    output logic [WI+WF-1:0]         oz,
    output logic [WI+WF-1:0]         ow,
    output logic                     overflow
);

    localparam int W  = WI + WF;
    localparam int PW = 2 * W;
    localparam int AW = PW + 2;

    localparam logic signed [W-1:0]  ONE  = W'(2 ** WF);
    localparam logic signed [AW-1:0] HALF = AW'(2 ** (WF - 1));
    localparam logic signed [AW-1:0] MAXV = AW'(2 ** (W - 1) - 1);
    localparam logic signed [AW-1:0] MINV = AW'(-(2 ** (W - 1)));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state;

    logic        [3:0]    cnt;
    logic        [1:0]    row;
    logic        [1:0]    col;
    logic signed [AW-1:0] acc;

    logic signed [W-1:0]  mat_q [16];
    logic signed [W-1:0]  vec_q [3];

    logic                 accept;

    logic signed [W-1:0]  mul_a;
    logic signed [W-1:0]  mul_b;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] rnd;
    logic signed [AW-1:0] shifted;
    logic        [W-1:0]  row_res;
    logic                 row_sat;

    assign row    = cnt[3:2];
    assign col    = cnt[1:0];
    assign accept = (state == IDLE) && in_valid;

    // Operand capture: data registers need no reset, they are
    // always reloaded before being used.
    always_ff @(posedge Clk) begin
        if (accept) begin
            for (int k = 0; k < 16; k++) begin
                mat_q[k] <= model_matrix[k*W +: W];
            end
            vec_q[0] <= vx;
            vec_q[1] <= vy;
            vec_q[2] <= vz;
        end
    end

    // Column 3 multiplies the implicit w = 1.0.
    always_comb begin
        mul_a = mat_q[cnt];
        mul_b = ONE;
        case (col)
            2'd0:    mul_b = vec_q[0];
            2'd1:    mul_b = vec_q[1];
            2'd2:    mul_b = vec_q[2];
            default: mul_b = ONE;
        endcase
    end

    // Sign-extend before multiplying so the full-width product is exact.
    always_comb begin
        a_ext = PW'(mul_a);
        b_ext = PW'(mul_b);
        prod  = a_ext * b_ext;
        sum   = acc + AW'(prod);
    end

    // Round half-up, drop WF fraction bits, then clamp to W bits.
    always_comb begin
        rnd     = sum + HALF;
        shifted = rnd >>> WF;
        row_sat = 1'b0;
        row_res = shifted[W-1:0];
        if (shifted > MAXV) begin
            row_sat = 1'b1;
            row_res = MAXV[W-1:0];
        end else if (shifted < MINV) begin
            row_sat = 1'b1;
            row_res = MINV[W-1:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            ox        <= '0;
            oy        <= '0;
            oz        <= '0;
            ow        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= MAC;
                        cnt      <= '0;
                        acc      <= '0;
                        overflow <= 1'b0;
                        in_ready <= 1'b0;
                    end
                end

                MAC: begin
                    cnt <= cnt + 4'd1;
                    if (col == 2'd3) begin
                        acc <= '0;
                        case (row)
                            2'd0:    ox <= row_res;
                            2'd1:    oy <= row_res;
                            2'd2:    oz <= row_res;
                            default: ow <= row_res;
                        endcase
                        if (row_sat) begin
                            overflow <= 1'b1;
                        end
                    end else begin
                        acc <= sum;
                    end
                    if (cnt == 4'd15) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_transform.sv
// Directed bench for vertex_transform with a result scoreboard.
// Expected vertices are queued at accept and checked when out_valid rises.
module tb_vertex_transform;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          in_valid;
    logic          in_ready;
    logic [255:0]  model_matrix;
    logic [15:0]   vx, vy, vz;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   ox, oy, oz, ow;
    logic          overflow;

    vertex_transform #(.WI(8), .WF(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .model_matrix (model_matrix),
        .vx           (vx),
        .vy           (vy),
        .vz           (vz),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ox           (ox),
        .oy           (oy),
        .oz           (oz),
        .ow           (ow),
        .overflow     (overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [15:0] w;
        logic        ovf;
    } res_t;

    res_t        sb[$];
    logic [15:0] mm [16];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic [15:0] x, y, z, w,
                                input logic ovf);
        res_t r;
        r.x = x; r.y = y; r.z = z; r.w = w; r.ovf = ovf;
        return r;
    endfunction

    function automatic logic [255:0] pack_m();
        logic [255:0] p;
        for (int k = 0; k < 16; k++) p[k*16 +: 16] = mm[k];
        return p;
    endfunction

    // Reference: exact integer sum, +0.5 LSB, floor shift, clamp.
    function automatic res_t model(input logic [15:0] x, y, z);
        longint      v [4];
        longint      s;
        longint      q;
        logic [15:0] o [4];
        res_t        r;
        r.ovf = 1'b0;
        v[0] = longint'($signed(x));
        v[1] = longint'($signed(y));
        v[2] = longint'($signed(z));
        v[3] = 256;
        for (int rr = 0; rr < 4; rr++) begin
            s = 0;
            for (int c = 0; c < 4; c++)
                s += longint'($signed(mm[rr*4 + c])) * v[c];
            q = (s + 128) >>> 8;
            if (q > 32767) begin
                o[rr] = 16'h7FFF; r.ovf = 1'b1;
            end else if (q < -32768) begin
                o[rr] = 16'h8000; r.ovf = 1'b1;
            end else begin
                o[rr] = q[15:0];
            end
        end
        r.x = o[0]; r.y = o[1]; r.z = o[2]; r.w = o[3];
        return r;
    endfunction

    task automatic clear_m();
        for (int k = 0; k < 16; k++) mm[k] = 16'h0000;
    endtask

    task automatic ident_m();
        clear_m();
        mm[0] = 16'h0100; mm[5] = 16'h0100;
        mm[10] = 16'h0100; mm[15] = 16'h0100;
    endtask

    task automatic send(input logic [15:0] x, y, z, input res_t e);
        int n = 0;
        @(negedge Clk);
        while (!in_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        model_matrix = pack_m();
        vx = x; vy = y; vz = z;
        in_valid = 1'b1;
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        model_matrix = {8{32'hDEADBEEF}};
        vx = 16'h5A5A; vy = 16'hA5A5; vz = 16'h7777;
        sb.push_back(e);
    endtask

    task automatic get_result(input string tag, input int hold);
        int   n = 0;
        res_t e;
        @(negedge Clk);
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        while (!out_valid && n < 60) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else if (out_valid) begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'd16);
            chk({tag, "_ox"}, 32'(ox), 32'(e.x));
            chk({tag, "_oy"}, 32'(oy), 32'(e.y));
            chk({tag, "_oz"}, 32'(oz), 32'(e.z));
            chk({tag, "_ow"}, 32'(ow), 32'(e.w));
            chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
            for (int i = 0; i < hold; i++) begin
                in_valid = i[0];
                vx = 16'h1234;
                @(negedge Clk);
                chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
                chk({tag, "_hold_out"}, {ox, ow}, {e.x, e.w});
                chk({tag, "_hold_mid"}, {oy, oz}, {e.y, e.z});
                chk({tag, "_hold_ovf"}, 32'(overflow), 32'(e.ovf));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge Clk);
            #1;
            out_ready = 1'b0;
            @(negedge Clk);
            chk({tag, "_drop_v"}, 32'(out_valid), 32'd0);
            chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (out_valid) hits++;
        end
        chk(tag, 32'(hits), 32'd0);
    endtask

    initial begin
        res_t e;
        Reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_matrix = '0;
        vx = '0; vy = '0; vz = '0;
        clear_m();
        repeat (3) @(negedge Clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", {ox, oy}, 32'd0);
        chk("rst_outputs2", {oz, ow}, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Identity
        ident_m();
        send(16'h0100, 16'h0200, 16'h0300,
             mk(16'h0100, 16'h0200, 16'h0300, 16'h0100, 1'b0));
        get_result("ident", 0);

        // Scale 2.0, translate (1,0,0)
        clear_m();
        mm[0] = 16'h0200; mm[3] = 16'h0100;
        mm[5] = 16'h0200; mm[10] = 16'h0200; mm[15] = 16'h0100;
        send(16'h0100, 16'h0100, 16'h0100,
             mk(16'h0300, 16'h0200, 16'h0200, 16'h0100, 1'b0));
        get_result("scale", 0);

        // Signed product with rounding
        clear_m();
        mm[0] = 16'hFE80;
        send(16'h0080, 16'h0000, 16'h0000,
             mk(16'hFF40, 16'h0000, 16'h0000, 16'h0000, 1'b0));
        get_result("neg_round", 0);

        mm[0] = 16'h0001;
        send(16'h0080, 16'h0000, 16'h0000,
             mk(16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0));
        get_result("half_up", 0);

        // Saturation both ways, then a clean vertex
        mm[0] = 16'h7F00;
        send(16'h0200, 16'h0000, 16'h0000,
             mk(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b1));
        get_result("sat_pos", 0);

        mm[0] = 16'h8000;
        send(16'h0200, 16'h0000, 16'h0000,
             mk(16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1));
        get_result("sat_neg", 0);

        ident_m();
        send(16'h0100, 16'hFF00, 16'h0040,
             mk(16'h0100, 16'hFF00, 16'h0040, 16'h0100, 1'b0));
        get_result("clean_after_sat", 0);

        // Backpressure with in_valid pulses during DONE
        send(16'h0300, 16'h0200, 16'h0100,
             mk(16'h0300, 16'h0200, 16'h0100, 16'h0100, 1'b0));
        get_result("backpressure", 5);
        quiet("no_second_result", 25);

        // Reset in the middle of MAC
        clear_m();
        mm[0] = 16'h0200; mm[3] = 16'h0100;
        mm[5] = 16'h0200; mm[10] = 16'h0200; mm[15] = 16'h0100;
        send(16'h0100, 16'h0100, 16'h0100,
             mk(16'h0300, 16'h0200, 16'h0200, 16'h0100, 1'b0));
        repeat (7) @(posedge Clk);
        #1;
        Reset = 1'b1;
        sb.delete();
        @(negedge Clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out", {ox, oy}, 32'd0);
        chk("mid_rst_out2", {oz, ow}, 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        quiet("no_emit_after_rst", 20);
        send(16'h0100, 16'h0100, 16'h0100,
             mk(16'h0300, 16'h0200, 16'h0200, 16'h0100, 1'b0));
        get_result("after_rst", 0);

        // A few random matrices against the reference model
        for (int t = 0; t < 4; t++) begin
            logic [15:0] x, y, z;
            for (int k = 0; k < 16; k++)
                mm[k] = 16'(int'($urandom_range(0, 1023)) - 512);
            x = 16'(int'($urandom_range(0, 8191)) - 4096);
            y = 16'(int'($urandom_range(0, 8191)) - 4096);
            z = 16'(int'($urandom_range(0, 8191)) - 4096);
            e = model(x, y, z);
            send(x, y, z, e);
            get_result("random", 0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
